iru_out_drain: RTL
==================

IRU_OUT_DRAIN -- requirements
Module: iru_out_drain

Interface
REQ-001 Parameters: the block SHALL have no parameters; geometry is fixed at 5 buffers x 80 bytes, 8-byte beats.
REQ-002 clk  input  1  clock; all state SHALL update on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 img_done  input  1  single-cycle pulse from the rotation stage: the output image buffer is fully written.
REQ-005 q  input  [7:0] x [4:0][79:0]  image bytes from the output buffer; q[b][i] is buffer b, byte i (row i/20, col i%20 within that buffer's 4 rows).
REQ-006 busy  output  1  high while draining or clearing; the rotation stage SHALL NOT write the buffer while busy=1.
REQ-007 z  output  1  one-cycle synchronous clear request to the output buffer.
REQ-008 out_valid  output  1  beat valid.
REQ-009 out_ready  input  1  downstream accepts the beat.
REQ-010 out_data  output  64  beat payload; byte k (bits 8k+7:8k) = q[buf][beat*8+k], k=0..7.
REQ-011 out_buf  output  3  buffer index of the current beat, 0..4.
REQ-012 out_last  output  1  high on the final beat of the image (buf 4, beat 9).
REQ-013 img_count  output  16  count of fully drained images, wraps 65535->0.
REQ-014 overrun  output  1  sticky flag: img_done seen while busy.

Function
REQ-015 FSM states SHALL be IDLE, DRAIN, CLEAR; encoding is free.
REQ-016 IDLE: busy=0, out_valid=0, z=0; img_done=1 SHALL move to DRAIN next cycle with buf=0, beat=0.
REQ-017 DRAIN: out_valid=1, busy=1; out_data, out_buf and out_last SHALL derive from the current counters and q.
REQ-018 A beat transfers when out_valid & out_ready; with no transfer, counters, out_data and out_valid SHALL hold.
REQ-019 On transfer, beat SHALL increment 0..9; at beat 9 it SHALL wrap to 0 and buf SHALL increment.
REQ-020 Transfer with buf=4, beat=9 (out_last=1) SHALL move to CLEAR; exactly 50 beats per image.
REQ-021 CLEAR SHALL last exactly one cycle: z=1, busy=1, out_valid=0; img_count SHALL increment by 1; next state IDLE.
REQ-022 Back-to-back transfers SHALL sustain 1 beat/cycle; minimum image latency, img_done to CLEAR exit, is 52 cycles.
REQ-023 img_done while busy SHALL be ignored for sequencing and SHALL set overrun=1; overrun clears only on reset.
REQ-024 img_done in the CLEAR cycle SHALL count as overrun; it is not queued.
REQ-025 out_ready while out_valid=0 SHALL have no effect.
REQ-026 The block SHALL NOT register q; q is stable while busy=1 per REQ-006.

Reset
REQ-027 rst_n=0 SHALL force IDLE immediately, with buf=0, beat=0, busy=0, z=0, out_valid=0, out_last=0, out_buf=0, img_count=0 and overrun=0.
REQ-028 out_data SHALL be 0 while out_valid=0.
REQ-029 Reset mid-DRAIN SHALL abandon the image with no z pulse and no count; the first cycle after release is IDLE.

Verification
REQ-030 Fill q with q[b][i]=b*80+i mod 256, pulse img_done, hold out_ready=1 -> 50 consecutive beats; beat 0 data=0x0706050403020100; beat 10 out_buf=1, byte0=0x50; beat 49 out_last=1, byte7=0x8F; then z=1 for one cycle; img_count=1.
REQ-031 Random out_ready at 30% duty -> data and out_buf stable while stalled; beat order is identical to REQ-030; exactly one z pulse.
REQ-032 img_done pulsed at beat 20 and in the CLEAR cycle -> drain is unaffected, overrun=1, img_count=1, the next IDLE ignores nothing.
REQ-033 rst_n asserted at beat 25 -> all outputs 0 asynchronously; a new img_done restarts at buf=0, beat=0.
REQ-034 Preload img_count=65535 by 65535 drains (or force) and drain once more -> img_count=0.
REQ-035 out_ready=1 while IDLE for 10 cycles -> out_valid=0 and no state change.

Source files
------------

// File: rtl/iru_out_drain.sv
// Output drain for the rotation unit's image buffer. After img_done it
// streams the 5 x 80-byte buffer as 50 eight-byte beats over a
// valid/ready port, then pulses z for one cycle to clear the buffer.
// q is read combinationally; it must stay stable while busy is high.

// One output byte lane: picks byte (beat*8 + LANE) of the current buffer.
module iru_out_drain_lane #(
    parameter int LANE = 0
) (
    input  logic [4:0][79:0][7:0] q,
    input  logic [2:0]            buf_idx,
    input  logic [3:0]            beat,
    input  logic                  en,
    output logic [7:0]            byte_o
);
    logic [6:0] idx;

    // Byte select; forced to zero whenever no beat is being offered.
    always_comb begin
        idx    = {beat, 3'b000} + 7'(LANE);
        byte_o = en ? q[buf_idx][idx] : 8'h00;
    end
endmodule

module iru_out_drain (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  img_done,
    input  logic [4:0][79:0][7:0] q,
    output logic                  busy,
    output logic                  z,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [63:0]           out_data,
    output logic [2:0]            out_buf,
    output logic                  out_last,
    output logic [15:0]           img_count,
    output logic                  overrun
);
    localparam int          NUM_LANES = 8;
    localparam logic [2:0]  LAST_BUF  = 3'd4;
    localparam logic [3:0]  LAST_BEAT = 4'd9;

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    state_t     state_q, state_d;
    logic [2:0] buf_q;
    logic [3:0] beat_q;
    logic [15:0] cnt_q;
    logic       ovr_q;
    logic       xfer;
    logic       at_last;
    logic [NUM_LANES-1:0][7:0] lane_byte;

    assign xfer    = out_valid & out_ready;
    assign at_last = (buf_q == LAST_BUF) && (beat_q == LAST_BEAT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and per-state outputs.
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        z         = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (img_done) state_d = DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (xfer && at_last) state_d = CLEAR;
            end
            CLEAR: begin
                busy    = 1'b1;
                z       = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Buffer/beat counters: advance only on an accepted beat, wrap after the
    // last beat so the next image starts at buf 0, beat 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q  <= '0;
            beat_q <= '0;
        end else if (state_q == IDLE && img_done) begin
            buf_q  <= '0;
            beat_q <= '0;
        end else if (xfer) begin
            if (beat_q == LAST_BEAT) begin
                beat_q <= '0;
                buf_q  <= (buf_q == LAST_BUF) ? 3'd0 : buf_q + 3'd1;
            end else begin
                beat_q <= beat_q + 4'd1;
            end
        end
    end

    // Completed-image counter (bumped in the clear cycle) and sticky overrun
    // for any img_done that arrives while the buffer is still owned here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovr_q <= 1'b0;
        end else begin
            if (state_q == CLEAR)          cnt_q <= cnt_q + 16'd1;
            if (img_done && state_q != IDLE) ovr_q <= 1'b1;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_LANES; k++) begin : g_lane
            iru_out_drain_lane #(.LANE(k)) u_lane (
                .q       (q),
                .buf_idx (buf_q),
                .beat    (beat_q),
                .en      (out_valid),
                .byte_o  (lane_byte[k])
            );
        end
    endgenerate

    assign out_data  = lane_byte;
    assign out_buf   = buf_q;
    assign out_last  = out_valid & at_last;
    assign img_count = cnt_q;
    assign overrun   = ovr_q;
endmodule
